// File: rtl/tlc_pkg.sv
// Shared definitions for the crossroad lamp guard: lamp codes, direction
// indices, guard FSM states and failsafe cause codes.
package tlc_pkg;

    typedef logic [2:0] light_t;
    typedef light_t [3:0] lamp_set_t;   // index 0 = north, 1 = west, 2 = south, 3 = east

    localparam light_t RED = 3'b100;
    localparam light_t YEL = 3'b010;
    localparam light_t GRN = 3'b001;
    localparam light_t OFF = 3'b000;

    localparam lamp_set_t ALL_RED = {4{RED}};
    localparam lamp_set_t ALL_OFF = {4{OFF}};

    // Bit 2 set means "no active direction".
    typedef logic [2:0] dir_t;
    localparam dir_t DIR_N    = 3'd0;
    localparam dir_t DIR_W    = 3'd1;
    localparam dir_t DIR_S    = 3'd2;
    localparam dir_t DIR_E    = 3'd3;
    localparam dir_t DIR_NONE = 3'd4;

    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        RUN     = 2'd1,
        CLEAR   = 2'd2,
        FAULT   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_INVALID  = 2'b01,
        CAUSE_CONFLICT = 2'b10,
        CAUSE_BOTH     = 2'b11
    } cause_t;

endpackage

// File: rtl/tlc_code_check.sv
// Combinational legality check of the four controller codes and
// identification of the single non-red (active) direction.
module tlc_code_check
    import tlc_pkg::*;
(
    input  lamp_set_t  codes,
    output logic       invalid,
    output logic       conflict,
    output logic       active_valid,
    output logic [1:0] active_dir
);

    logic [3:0] non_red;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        invalid    = 1'b0;
        non_red    = '0;
        active_dir = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (codes[i] != RED && codes[i] != YEL && codes[i] != GRN) begin
                invalid = 1'b1;
            end
            non_red[i] = (codes[i] != RED);
            if (codes[i] != RED) begin
                active_dir = 2'(i);
            end
        end
    end

    assign conflict     = ($countones(non_red) > 1);
    assign active_valid = ($countones(non_red) == 1);

endmodule

// File: rtl/tlc_lamp_guard.sv
// Registered output stage between the crossroad controller and the lamp
// drivers: all-red startup, all-red clearance on direction change, and a
// latched flashing-red failsafe on persistent illegal codes.
module tlc_lamp_guard
    import tlc_pkg::*;
#(
    parameter int unsigned STARTUP_CYC   = 8,
    parameter int unsigned CLEAR_CYC     = 2,
    parameter int unsigned FAULT_PERSIST = 2,
    parameter int unsigned BLINK_HALF    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] north_light,
    input  logic [2:0] west_light,
    input  logic [2:0] south_light,
    input  logic [2:0] east_light,
    output logic [2:0] north_lamp,
    output logic [2:0] west_lamp,
    output logic [2:0] south_lamp,
    output logic [2:0] east_lamp,
    output logic       clearing,
    output logic       fault,
    output logic [1:0] fault_cause
);

    localparam int SW = $clog2(STARTUP_CYC) + 1;
    localparam int CW = $clog2(CLEAR_CYC) + 1;
    localparam int PW = $clog2(FAULT_PERSIST) + 1;
    localparam int BW = $clog2(BLINK_HALF) + 1;

    lamp_set_t lights;
    logic      invalid, conflict, active_valid, illegal, trip, run_eval;
    logic [1:0] active_dir;
    dir_t      in_dir;

    state_t    state_q, state_d;
    logic [SW-1:0] start_cnt_q, start_cnt_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic [PW-1:0] persist_q, persist_d;
    logic [BW-1:0] blink_q, blink_d;
    logic      blink_off_q, blink_off_d;
    dir_t      last_dir_q, last_dir_d;
    lamp_set_t lamps_q, lamps_d;
    logic      clearing_q, clearing_d;
    logic      fault_q, fault_d;
    cause_t    cause_q, cause_d;

    assign lights = {east_light, south_light, west_light, north_light};

    tlc_code_check u_check (
        .codes        (lights),
        .invalid      (invalid),
        .conflict     (conflict),
        .active_valid (active_valid),
        .active_dir   (active_dir)
    );

    assign illegal = invalid | conflict;
    assign trip    = illegal && (persist_q >= PW'(FAULT_PERSIST - 1));
    assign in_dir  = active_valid ? {1'b0, active_dir} : DIR_NONE;

    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        clr_cnt_d   = clr_cnt_q;
        blink_d     = blink_q;
        blink_off_d = blink_off_q;
        last_dir_d  = last_dir_q;
        lamps_d     = lamps_q;
        clearing_d  = 1'b0;
        fault_d     = fault_q;
        cause_d     = cause_q;
        run_eval    = 1'b0;
        persist_d   = '0;
        if (illegal) begin
            persist_d = (persist_q == PW'(FAULT_PERSIST)) ? persist_q : persist_q + PW'(1);
        end

        if (state_q == FAULT) begin
            // Inputs are ignored; only the flash generator advances.
            persist_d = persist_q;
            if (blink_q == BW'(BLINK_HALF - 1)) begin
                blink_d     = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_d = blink_q + BW'(1);
            end
            lamps_d = blink_off_d ? ALL_OFF : ALL_RED;
        end else if (trip) begin
            state_d     = FAULT;
            fault_d     = 1'b1;
            cause_d     = cause_t'({conflict, invalid});
            blink_d     = '0;
            blink_off_d = 1'b0;
            lamps_d     = ALL_RED;
        end else begin
            unique case (state_q)
                STARTUP: begin
                    lamps_d = ALL_RED;
                    if (start_cnt_q == SW'(STARTUP_CYC - 1)) begin
                        state_d = RUN;
                    end else begin
                        start_cnt_d = start_cnt_q + SW'(1);
                    end
                end
                RUN: run_eval = 1'b1;
                CLEAR: begin
                    if (clr_cnt_q < CW'(CLEAR_CYC)) begin
                        clr_cnt_d  = clr_cnt_q + CW'(1);
                        clearing_d = 1'b1;
                        lamps_d    = ALL_RED;
                    end else begin
                        run_eval = 1'b1;
                    end
                end
                default: ;
            endcase

            // Illegal samples below the trip threshold leave the lamps held.
            if (run_eval) begin
                state_d = RUN;
                if (!illegal) begin
                    if (!active_valid || last_dir_q == DIR_NONE || in_dir == last_dir_q) begin
                        lamps_d = lights;
                        if (active_valid) begin
                            last_dir_d = in_dir;
                        end
                    end else begin
                        state_d    = CLEAR;
                        clr_cnt_d  = CW'(1);
                        clearing_d = 1'b1;
                        lamps_d    = ALL_RED;
                        last_dir_d = in_dir;
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= STARTUP;
            start_cnt_q <= '0;
            clr_cnt_q   <= '0;
            persist_q   <= '0;
            blink_q     <= '0;
            blink_off_q <= 1'b0;
            last_dir_q  <= DIR_NONE;
            lamps_q     <= ALL_RED;
            clearing_q  <= 1'b0;
            fault_q     <= 1'b0;
            cause_q     <= CAUSE_NONE;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            clr_cnt_q   <= clr_cnt_d;
            persist_q   <= persist_d;
            blink_q     <= blink_d;
            blink_off_q <= blink_off_d;
            last_dir_q  <= last_dir_d;
            lamps_q     <= lamps_d;
            clearing_q  <= clearing_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
        end
    end

    assign north_lamp  = lamps_q[0];
    assign west_lamp   = lamps_q[1];
    assign south_lamp  = lamps_q[2];
    assign east_lamp   = lamps_q[3];
    assign clearing    = clearing_q;
    assign fault       = fault_q;
    assign fault_cause = cause_q;

endmodule

// File: tb/tb_tlc_lamp_guard.sv
// Table-driven bench for tlc_lamp_guard: each vector's expected outputs are
// queued when its inputs are driven and compared after the following edge.
module tb_tlc_lamp_guard;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [11:0] ALLR = {R, R, R, R};
    localparam logic [11:0] ALLO = 12'h000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] north_light, west_light, south_light, east_light;
    logic [2:0] north_lamp, west_lamp, south_lamp, east_lamp;
    logic       clearing, fault;
    logic [1:0] fault_cause;
    logic [15:0] outs;

    int n_checks = 0;
    int n_errors = 0;

    // Inputs and expected outputs are packed {N, W, S, E} / {N, W, S, E, clearing, fault, cause}.
    typedef struct {
        string        name;
        int           reps;
        logic [11:0]  lights;
        logic [15:0]  exp;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] sb_q[$];
    string       nm_q[$];

    tlc_lamp_guard #(
        .STARTUP_CYC   (8),
        .CLEAR_CYC     (2),
        .FAULT_PERSIST (2),
        .BLINK_HALF    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .north_light (north_light),
        .west_light  (west_light),
        .south_light (south_light),
        .east_light  (east_light),
        .north_lamp  (north_lamp),
        .west_lamp   (west_lamp),
        .south_lamp  (south_lamp),
        .east_lamp   (east_lamp),
        .clearing    (clearing),
        .fault       (fault),
        .fault_cause (fault_cause)
    );

    always #5 clk = ~clk;

    assign outs = {north_lamp, west_lamp, south_lamp, east_lamp, clearing, fault, fault_cause};

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: lamps/clr/flt/cause got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input string name, input int reps, input logic [11:0] lights,
                       input logic [11:0] lamps, input logic clr, input logic flt,
                       input logic [1:0] cause);
        vec_t v;
        v.name   = name;
        v.reps   = reps;
        v.lights = lights;
        v.exp    = {lamps, clr, flt, cause};
        vecs.push_back(v);
    endtask

    task automatic step(input string name, input logic [11:0] lights, input logic [15:0] exp);
        {north_light, west_light, south_light, east_light} = lights;
        sb_q.push_back(exp);
        nm_q.push_back(name);
        @(posedge clk);
        #1;
        check(nm_q.pop_front(), outs, sb_q.pop_front());
    endtask

    task automatic run(input int first, input int last);
        for (int i = first; i < last; i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                step(vecs[i].name, vecs[i].lights, vecs[i].exp);
            end
        end
    endtask

    int seg_a_end;

    initial begin
        {north_light, west_light, south_light, east_light} = {G, R, R, R};

        // Segment A: startup, normal cycle, glitch, clearance corners, conflict trip.
        add("startup",      8, {G, R, R, R},       ALLR,         1'b0, 1'b0, 2'b00);
        add("n_green",     16, {G, R, R, R},       {G, R, R, R}, 1'b0, 1'b0, 2'b00);
        add("n_yellow",     4, {Y, R, R, R},       {Y, R, R, R}, 1'b0, 1'b0, 2'b00);
        add("w_clear",      2, {R, G, R, R},       ALLR,         1'b1, 1'b0, 2'b00);
        add("w_green",      3, {R, G, R, R},       {R, G, R, R}, 1'b0, 1'b0, 2'b00);
        add("glitch_hold",  1, {3'b011, G, R, R},  {R, G, R, R}, 1'b0, 1'b0, 2'b00);
        add("resume",       2, {R, G, R, R},       {R, G, R, R}, 1'b0, 1'b0, 2'b00);
        add("all_red",      2, ALLR,               ALLR,         1'b0, 1'b0, 2'b00);
        add("w_yellow",     1, {R, Y, R, R},       {R, Y, R, R}, 1'b0, 1'b0, 2'b00);
        add("s_clear",      1, {R, R, G, R},       ALLR,         1'b1, 1'b0, 2'b00);
        add("clear_allred", 1, ALLR,               ALLR,         1'b1, 1'b0, 2'b00);
        add("exit_allred",  1, ALLR,               ALLR,         1'b0, 1'b0, 2'b00);
        add("s_yellow",     1, {R, R, Y, R},       {R, R, Y, R}, 1'b0, 1'b0, 2'b00);
        add("conflict_1",   1, {G, R, G, R},       {R, R, Y, R}, 1'b0, 1'b0, 2'b00);
        add("conflict_trip",1, {G, R, G, R},       ALLR,         1'b0, 1'b1, 2'b10);
        add("blink_red",    3, {G, R, R, R},       ALLR,         1'b0, 1'b1, 2'b10);
        add("blink_off",    4, {G, R, R, R},       ALLO,         1'b0, 1'b1, 2'b10);
        add("blink_red2",   4, {R, G, R, R},       ALLR,         1'b0, 1'b1, 2'b10);
        add("blink_off2",   2, {R, G, R, R},       ALLO,         1'b0, 1'b1, 2'b10);
        seg_a_end = vecs.size();

        // Segment B: restart after reset, then invalid+conflict during clearance.
        add("restart",      8, {G, R, R, R},       ALLR,         1'b0, 1'b0, 2'b00);
        add("n_pass",       1, {G, R, R, R},       {G, R, R, R}, 1'b0, 1'b0, 2'b00);
        add("w_clear_b",    1, {R, G, R, R},       ALLR,         1'b1, 1'b0, 2'b00);
        add("both_1",       1, {3'b111, R, R, G},  ALLR,         1'b1, 1'b0, 2'b00);
        add("both_trip",    1, {3'b111, R, R, G},  ALLR,         1'b0, 1'b1, 2'b11);
        add("ignored_red",  3, {R, G, R, R},       ALLR,         1'b0, 1'b1, 2'b11);
        add("ignored_off",  1, {R, G, R, R},       ALLO,         1'b0, 1'b1, 2'b11);

        #12;
        check("reset_state", outs, {ALLR, 1'b0, 1'b0, 2'b00});
        @(negedge clk);
        rst = 1'b0;
        run(0, seg_a_end);

        // Asynchronous reset in the middle of a dark flash phase.
        #2;
        rst = 1'b1;
        #1;
        check("reset_in_fault", outs, {ALLR, 1'b0, 1'b0, 2'b00});
        @(negedge clk);
        rst = 1'b0;
        run(seg_a_end, vecs.size());

        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
